// File: rtl/adl_spi_axil_bridge.sv
// ----------------------------------------------------------------------------
// adl_spi_axil_bridge
//   AXI4-Lite slave that launches 24-bit SPI mode-0 frames to an ADL5960.
//   Register map (word addresses):
//     0x0 CTRL   bit0 START (write-1 pulse, reads 0)
//     0x4 TXDATA bits[23:0] frame {rw, addr[14:0], data[7:0]}
//     0x8 RXDATA bits[7:0]  last 8 bits shifted in
//     0xC STATUS bit0 BUSY, bit1 DONE (W1C), bit2 OVERRUN (W1C)
//   Ports:
//     ACLK, ARESETN          clock, synchronous active-low reset
//     S_AXI_AW*/W*/B*        AXI4-Lite write channels (PROT ignored)
//     S_AXI_AR*/R*           AXI4-Lite read channels (PROT ignored)
//     spi_cs_n/sclk/mosi     SPI master outputs, spi_miso input
//   Build option: define ADL_SPI_LOOPBACK_EN to sample MISO from spi_mosi.
// ----------------------------------------------------------------------------
module adl_spi_axil_bridge #(
    parameter int C_S_AXI_DATA_WIDTH = 32,
    parameter int C_S_AXI_ADDR_WIDTH = 4,
    parameter int CLK_DIV            = 4
) (
    input  logic                            ACLK,
    input  logic                            ARESETN,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_AWADDR,
    input  logic [2:0]                      S_AXI_AWPROT,
    input  logic                            S_AXI_AWVALID,
    output logic                            S_AXI_AWREADY,
    input  logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_WDATA,
    input  logic [C_S_AXI_DATA_WIDTH/8-1:0] S_AXI_WSTRB,
    input  logic                            S_AXI_WVALID,
    output logic                            S_AXI_WREADY,
    output logic [1:0]                      S_AXI_BRESP,
    output logic                            S_AXI_BVALID,
    input  logic                            S_AXI_BREADY,
    input  logic [C_S_AXI_ADDR_WIDTH-1:0]   S_AXI_ARADDR,
    input  logic [2:0]                      S_AXI_ARPROT,
    input  logic                            S_AXI_ARVALID,
    output logic                            S_AXI_ARREADY,
    output logic [C_S_AXI_DATA_WIDTH-1:0]   S_AXI_RDATA,
    output logic [1:0]                      S_AXI_RRESP,
    output logic                            S_AXI_RVALID,
    input  logic                            S_AXI_RREADY,
    output logic                            spi_cs_n,
    output logic                            spi_sclk,
    output logic                            spi_mosi,
    input  logic                            spi_miso
);

    typedef enum logic [1:0] {ST_IDLE, ST_SETUP, ST_SHIFT, ST_HOLD} state_t;

    localparam int             CW       = $clog2(CLK_DIV);
    localparam logic [CW-1:0]  CNT_LAST = CW'(CLK_DIV - 1);

    state_t         r_state, w_state_next;
    logic           r_wr_ready, r_bvalid, r_rd_ready, r_rvalid;
    logic [31:0]    r_rdata, w_rd_mux;
    logic [23:0]    r_txdata, r_sh;
    logic [7:0]     r_rxdata;
    logic           r_done, r_ovr;
    logic [CW-1:0]  r_cnt;
    logic [4:0]     r_bit;
    logic           r_sclk, r_cs_n, r_mosi, r_miso_s;
    logic           w_wr_fire, w_rd_fire, w_start_req, w_clr, w_busy, w_half_end;
    logic           w_load, w_rise, w_fall, w_finish, w_miso_in;
    logic           w_unused;

`ifdef ADL_SPI_LOOPBACK_EN
    assign w_miso_in = r_mosi;
`else
    assign w_miso_in = spi_miso;
`endif

    assign w_unused = &{1'b0, S_AXI_AWPROT, S_AXI_ARPROT, S_AXI_AWADDR[1:0], S_AXI_ARADDR[1:0],
                        S_AXI_WDATA[31:24], S_AXI_WSTRB[3], spi_miso};

    // A handshake completes on the edge that ends the single-cycle READY pulse.
    assign w_wr_fire   = r_wr_ready && S_AXI_AWVALID && S_AXI_WVALID;
    assign w_rd_fire   = r_rd_ready && S_AXI_ARVALID;
    assign w_start_req = w_wr_fire && (S_AXI_AWADDR[3:2] == 2'd0) && S_AXI_WSTRB[0] && S_AXI_WDATA[0];
    assign w_clr       = w_wr_fire && (S_AXI_AWADDR[3:2] == 2'd3) && S_AXI_WSTRB[0];
    assign w_busy      = (r_state != ST_IDLE);
    assign w_half_end  = (r_cnt == CNT_LAST);

    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        w_state_next = r_state;
        w_load       = 1'b0;
        w_rise       = 1'b0;
        w_fall       = 1'b0;
        w_finish     = 1'b0;
        case (r_state)
            ST_IDLE: if (w_start_req) begin
                w_load       = 1'b1;
                w_state_next = ST_SETUP;
            end
            ST_SETUP: if (w_half_end) w_state_next = ST_SHIFT;
            ST_SHIFT: if (w_half_end) begin
                w_rise = !r_sclk;
                w_fall = r_sclk;
                if (r_sclk && (r_bit == 5'd23)) w_state_next = ST_HOLD;
            end
            ST_HOLD: if (w_half_end) begin
                w_finish     = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
        if (!ARESETN) r_state <= ST_IDLE;
        else          r_state <= w_state_next;
    end

    always_comb begin
        w_rd_mux = 32'd0;
        case (S_AXI_ARADDR[3:2])
            2'd1:    w_rd_mux = {8'd0, r_txdata};
            2'd2:    w_rd_mux = {24'd0, r_rxdata};
            2'd3:    w_rd_mux = {29'd0, r_ovr, r_done, w_busy};
            default: w_rd_mux = 32'd0;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (!ARESETN) begin
            r_wr_ready <= 1'b0;
            r_bvalid   <= 1'b0;
            r_rd_ready <= 1'b0;
            r_rvalid   <= 1'b0;
            r_rdata    <= 32'd0;
            r_txdata   <= 24'd0;
            r_rxdata   <= 8'd0;
            r_done     <= 1'b0;
            r_ovr      <= 1'b0;
            r_cnt      <= '0;
            r_bit      <= 5'd0;
            r_sclk     <= 1'b0;
            r_cs_n     <= 1'b1;
            r_mosi     <= 1'b0;
            r_miso_s   <= 1'b0;
            r_sh       <= 24'd0;
        end else begin
            // Write channel: READY is high for one cycle, B response follows.
            r_wr_ready <= !r_wr_ready && S_AXI_AWVALID && S_AXI_WVALID && !r_bvalid;
            if (w_wr_fire)                   r_bvalid <= 1'b1;
            else if (r_bvalid && S_AXI_BREADY) r_bvalid <= 1'b0;

            if (w_wr_fire && (S_AXI_AWADDR[3:2] == 2'd1)) begin
                for (int i = 0; i < 3; i++)
                    if (S_AXI_WSTRB[i]) r_txdata[8*i +: 8] <= S_AXI_WDATA[8*i +: 8];
            end

            // Read channel: data captured with the address, held until RREADY.
            r_rd_ready <= !r_rd_ready && S_AXI_ARVALID && !r_rvalid;
            if (w_rd_fire) begin
                r_rvalid <= 1'b1;
                r_rdata  <= w_rd_mux;
            end else if (r_rvalid && S_AXI_RREADY) begin
                r_rvalid <= 1'b0;
            end

            // Status bits: a hardware set in the same cycle as a W1C wins.
            if (w_finish)                          r_done <= 1'b1;
            else if (w_clr && S_AXI_WDATA[1])      r_done <= 1'b0;
            if (w_start_req && w_busy)             r_ovr  <= 1'b1;
            else if (w_clr && S_AXI_WDATA[2])      r_ovr  <= 1'b0;

            // SPI datapath: one shared counter times both SETUP/HOLD and SCLK halves.
            r_cnt <= (!w_busy || w_half_end) ? '0 : r_cnt + 1'b1;
            if (w_load) begin
                r_sh   <= r_txdata;
                r_mosi <= r_txdata[23];
                r_cs_n <= 1'b0;
                r_bit  <= 5'd0;
            end
            if (w_rise) begin
                r_sclk   <= 1'b1;
                r_miso_s <= w_miso_in;
            end
            if (w_fall) begin
                r_sclk <= 1'b0;
                r_bit  <= r_bit + 5'd1;
                r_sh   <= {r_sh[22:0], r_miso_s};
                r_mosi <= (r_bit == 5'd23) ? 1'b0 : r_sh[22];
            end
            if (w_finish) begin
                r_cs_n   <= 1'b1;
                r_rxdata <= r_sh[7:0];
            end
        end
    end

    assign S_AXI_AWREADY = r_wr_ready;
    assign S_AXI_WREADY  = r_wr_ready;
    assign S_AXI_BVALID  = r_bvalid;
    assign S_AXI_BRESP   = 2'b00;
    assign S_AXI_ARREADY = r_rd_ready;
    assign S_AXI_RVALID  = r_rvalid;
    assign S_AXI_RDATA   = r_rdata;
    assign S_AXI_RRESP   = 2'b00;
    assign spi_cs_n      = r_cs_n;
    assign spi_sclk      = r_sclk;
    assign spi_mosi      = r_mosi;

endmodule

// File: tb/tb_adl_spi_axil_bridge.sv
// ----------------------------------------------------------------------------
// tb_adl_spi_axil_bridge
//   Self-checking bench for adl_spi_axil_bridge (CLK_DIV = 4). A passive SPI
//   slave observes each frame and drives MISO; expectations come from a
//   register-level model of TXDATA/STATUS and the frame rules.
// ----------------------------------------------------------------------------
module tb_adl_spi_axil_bridge;

    localparam int CLK_DIV = 4;
    localparam int FRAME   = 50 * CLK_DIV;

    logic        ACLK = 1'b0;
    logic        ARESETN = 1'b0;
    logic [3:0]  S_AXI_AWADDR = '0, S_AXI_ARADDR = '0;
    logic [2:0]  S_AXI_AWPROT = '0, S_AXI_ARPROT = '0;
    logic        S_AXI_AWVALID = 1'b0, S_AXI_WVALID = 1'b0, S_AXI_BREADY = 1'b0;
    logic        S_AXI_ARVALID = 1'b0, S_AXI_RREADY = 1'b0;
    logic [31:0] S_AXI_WDATA = '0;
    logic [3:0]  S_AXI_WSTRB = '0;
    logic        S_AXI_AWREADY, S_AXI_WREADY, S_AXI_BVALID, S_AXI_ARREADY, S_AXI_RVALID;
    logic [1:0]  S_AXI_BRESP, S_AXI_RRESP;
    logic [31:0] S_AXI_RDATA;
    logic        spi_cs_n, spi_sclk, spi_mosi;
    logic        spi_miso = 1'b0;

    adl_spi_axil_bridge #(.C_S_AXI_DATA_WIDTH(32), .C_S_AXI_ADDR_WIDTH(4), .CLK_DIV(CLK_DIV)) dut (
        .ACLK(ACLK), .ARESETN(ARESETN),
        .S_AXI_AWADDR(S_AXI_AWADDR), .S_AXI_AWPROT(S_AXI_AWPROT), .S_AXI_AWVALID(S_AXI_AWVALID),
        .S_AXI_AWREADY(S_AXI_AWREADY), .S_AXI_WDATA(S_AXI_WDATA), .S_AXI_WSTRB(S_AXI_WSTRB),
        .S_AXI_WVALID(S_AXI_WVALID), .S_AXI_WREADY(S_AXI_WREADY), .S_AXI_BRESP(S_AXI_BRESP),
        .S_AXI_BVALID(S_AXI_BVALID), .S_AXI_BREADY(S_AXI_BREADY),
        .S_AXI_ARADDR(S_AXI_ARADDR), .S_AXI_ARPROT(S_AXI_ARPROT), .S_AXI_ARVALID(S_AXI_ARVALID),
        .S_AXI_ARREADY(S_AXI_ARREADY), .S_AXI_RDATA(S_AXI_RDATA), .S_AXI_RRESP(S_AXI_RRESP),
        .S_AXI_RVALID(S_AXI_RVALID), .S_AXI_RREADY(S_AXI_RREADY),
        .spi_cs_n(spi_cs_n), .spi_sclk(spi_sclk), .spi_mosi(spi_mosi), .spi_miso(spi_miso)
    );

    always #5 ACLK = ~ACLK;

    int errors = 0;
    int checks = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Passive SPI slave: counts CS-low cycles and SCLK rises, collects MOSI,
    // and presents MISO MSB first so it is stable before each rising edge.
    int          cs_low = 0, pulses = 0;
    logic [23:0] mosi_word = '0, miso_word = '0;
    logic        prev_cs = 1'b1, prev_sclk = 1'b0;

    initial forever begin
        @(negedge ACLK);
        if (prev_cs && !spi_cs_n) begin
            cs_low = 0; pulses = 0; mosi_word = '0;
        end
        if (!spi_cs_n) cs_low++;
        if (spi_sclk && !prev_sclk) begin
            pulses++;
            mosi_word = {mosi_word[22:0], spi_mosi};
        end
        spi_miso  = (!spi_cs_n && pulses < 24) ? miso_word[23 - pulses] : 1'b0;
        prev_cs   = spi_cs_n;
        prev_sclk = spi_sclk;
    end

    initial begin
        #500_000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d checks=%0d", errors, checks);
        $fatal(1, "watchdog");
    end

    // Reference model state.
    logic [23:0] m_tx = '0;
    logic        m_done = 1'b0, m_ovr = 1'b0;

    function automatic logic [23:0] merge(input logic [23:0] old, input logic [31:0] d, input logic [3:0] s);
        logic [23:0] r = old;
        for (int i = 0; i < 3; i++) if (s[i]) r[8*i +: 8] = d[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] exp_rx(input logic [23:0] tx, input logic [23:0] miso);
`ifdef ADL_SPI_LOOPBACK_EN
        return {24'd0, tx[7:0]};
`else
        return {24'd0, miso[7:0]};
`endif
    endfunction

    task automatic axi_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s);
        int n = 0;
        @(negedge ACLK);
        S_AXI_AWADDR = a; S_AXI_WDATA = d; S_AXI_WSTRB = s;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b1; S_AXI_BREADY = 1'b1;
        while (!S_AXI_AWREADY && n < 20) begin @(negedge ACLK); n++; end
        check("wr_ready_timeout", 32'(n < 20), 32'd1);
        @(negedge ACLK);
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        check("bresp", {30'd0, S_AXI_BRESP}, 32'd0);
        check("bvalid_after_hs", {31'd0, S_AXI_BVALID}, 32'd1);
        @(negedge ACLK);
        S_AXI_BREADY = 1'b0;
    endtask

    task automatic axi_read(input logic [3:0] a, output logic [31:0] d);
        int n = 0;
        @(negedge ACLK);
        S_AXI_ARADDR = a; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b1;
        while (!S_AXI_RVALID && n < 20) begin @(negedge ACLK); n++; end
        check("rd_timeout", 32'(n < 20), 32'd1);
        S_AXI_ARVALID = 1'b0;
        d = S_AXI_RDATA;
        check("rresp", {30'd0, S_AXI_RRESP}, 32'd0);
        @(negedge ACLK);
        S_AXI_RREADY = 1'b0;
    endtask

    task automatic wait_frame_end();
        int n = 0;
        while (spi_cs_n !== 1'b1 && n < 2 * FRAME) begin @(negedge ACLK); n++; end
        check("frame_end_timeout", 32'(n < 2 * FRAME), 32'd1);
        repeat (2) @(negedge ACLK);
    endtask

    task automatic run_frame(input string tag);
        logic [31:0] r;
        logic [23:0] sent = m_tx;
        axi_write(4'h0, 32'h1, 4'h1);
        axi_read(4'hC, r);
        check({tag, "_status_busy"}, r, {29'd0, m_ovr, m_done, 1'b1});
        wait_frame_end();
        m_done = 1'b1;
        check({tag, "_cs_low_cycles"}, 32'(cs_low), 32'(FRAME));
        check({tag, "_sclk_pulses"}, 32'(pulses), 32'd24);
        check({tag, "_mosi_word"}, {8'd0, mosi_word}, {8'd0, sent});
        axi_read(4'hC, r);
        check({tag, "_status_done"}, r, {29'd0, m_ovr, m_done, 1'b0});
        axi_read(4'h8, r);
        check({tag, "_rxdata"}, r, exp_rx(sent, miso_word));
    endtask

    initial begin
        logic [31:0] r, d, first;
        logic [3:0]  s;
        logic [23:0] old_tx;
        int          n, together, apart, cnt;

        // Reset state.
        repeat (3) @(negedge ACLK);
        check("rst_awready", {31'd0, S_AXI_AWREADY}, 32'd0);
        check("rst_bvalid", {31'd0, S_AXI_BVALID}, 32'd0);
        check("rst_arready_rvalid", {30'd0, S_AXI_ARREADY, S_AXI_RVALID}, 32'd0);
        check("rst_rdata", S_AXI_RDATA, 32'd0);
        check("rst_spi", {29'd0, spi_cs_n, spi_sclk, spi_mosi}, 32'd4);
        ARESETN = 1'b1;

        axi_read(4'hC, r); check("status_after_rst", r, 32'd0);
        axi_read(4'h4, r); check("tx_after_rst", r, 32'd0);

        // Register access and the directed frame.
        axi_write(4'h4, 32'h00A5C33C, 4'hF); m_tx = 24'hA5C33C;
        axi_read(4'h4, r); check("tx_readback", r, 32'h00A5C33C);
        axi_read(4'h0, r); check("ctrl_reads_zero", r, 32'd0);
        miso_word = 24'h0000D7;
        run_frame("frame0");

        // W1C ignored without WSTRB[0]; then cleared.
        axi_write(4'hC, 32'h6, 4'hE);
        axi_read(4'hC, r); check("w1c_strb_gated", r, 32'h2);
        axi_write(4'hC, 32'h2, 4'h1); m_done = 1'b0;
        axi_read(4'hC, r); check("w1c_done", r, 32'h0);

        // START without WSTRB[0] must not launch a frame.
        axi_write(4'h0, 32'h1, 4'hE);
        axi_read(4'hC, r); check("start_strb_gated", r, 32'h0);

        // Randomized TXDATA (byte-lane merges) and MISO patterns.
        for (int k = 0; k < 3; k++) begin
            d = $urandom; s = 4'($urandom_range(1, 15));
            axi_write(4'h4, d, s); m_tx = merge(m_tx, d, s);
            axi_read(4'h4, r); check("rand_tx_readback", r, {8'd0, m_tx});
            miso_word = 24'($urandom);
            run_frame("rand_frame");
            axi_write(4'hC, 32'h2, 4'h1); m_done = 1'b0;
        end

        // Overrun: START and a TXDATA write mid-frame leave the frame intact.
        old_tx = m_tx; miso_word = 24'h5A5A5A;
        axi_write(4'h0, 32'h1, 4'h1);
        repeat (40) @(negedge ACLK);
        axi_write(4'h0, 32'h1, 4'h1); m_ovr = 1'b1;
        axi_write(4'h4, 32'h00123456, 4'hF); m_tx = 24'h123456;
        axi_read(4'hC, r); check("ovr_status_busy", r, 32'h5);
        wait_frame_end(); m_done = 1'b1;
        check("ovr_sclk_pulses", 32'(pulses), 32'd24);
        check("ovr_mosi_word", {8'd0, mosi_word}, {8'd0, old_tx});
        axi_read(4'hC, r); check("ovr_status_after", r, 32'h6);
        axi_read(4'h8, r); check("ovr_rxdata", r, exp_rx(old_tx, miso_word));
        axi_read(4'h4, r); check("ovr_tx_updated", r, {8'd0, m_tx});
        axi_write(4'hC, 32'h6, 4'h1); m_done = 1'b0; m_ovr = 1'b0;
        axi_read(4'hC, r); check("ovr_cleared", r, 32'h0);

        // AW ahead of W, BREADY held low, RREADY held low.
        @(negedge ACLK);
        S_AXI_AWADDR = 4'h4; S_AXI_WDATA = 32'h00C0FFEE; S_AXI_WSTRB = 4'hF;
        S_AXI_AWVALID = 1'b1; S_AXI_WVALID = 1'b0; S_AXI_BREADY = 1'b0;
        cnt = 0;
        repeat (3) begin @(negedge ACLK); if (S_AXI_AWREADY || S_AXI_WREADY) cnt++; end
        check("aw_early_no_ready", 32'(cnt), 32'd0);
        S_AXI_WVALID = 1'b1;
        n = 0; together = 0; apart = 0;
        while (!S_AXI_BVALID && n < 20) begin
            @(negedge ACLK); n++;
            if (S_AXI_AWREADY && S_AXI_WREADY) together++;
            else if (S_AXI_AWREADY || S_AXI_WREADY) apart++;
        end
        S_AXI_AWVALID = 1'b0; S_AXI_WVALID = 1'b0;
        m_tx = 24'hC0FFEE;
        check("ready_pulse_together", 32'(together), 32'd1);
        check("ready_pulse_apart", 32'(apart), 32'd0);
        cnt = 0;
        repeat (5) begin if (S_AXI_BVALID) cnt++; @(negedge ACLK); end
        check("bvalid_hold", 32'(cnt), 32'd5);
        S_AXI_BREADY = 1'b1;
        @(negedge ACLK);
        check("bvalid_release", {31'd0, S_AXI_BVALID}, 32'd0);
        S_AXI_BREADY = 1'b0;

        S_AXI_ARADDR = 4'h4; S_AXI_ARVALID = 1'b1; S_AXI_RREADY = 1'b0;
        n = 0;
        while (!S_AXI_RVALID && n < 20) begin @(negedge ACLK); n++; end
        S_AXI_ARVALID = 1'b0;
        first = S_AXI_RDATA;
        check("rhold_data", first, {8'd0, m_tx});
        cnt = 0;
        repeat (4) begin @(negedge ACLK); if (S_AXI_RVALID && S_AXI_RDATA === first) cnt++; end
        check("rhold_stable", 32'(cnt), 32'd4);
        S_AXI_RREADY = 1'b1;
        @(negedge ACLK);
        check("rvalid_release", {31'd0, S_AXI_RVALID}, 32'd0);
        S_AXI_RREADY = 1'b0;

        // Reset mid-frame aborts it.
        axi_write(4'h0, 32'h1, 4'h1);
        repeat (95) @(negedge ACLK);
        ARESETN = 1'b0;
        @(negedge ACLK);
        check("midrst_spi", {30'd0, spi_cs_n, spi_sclk}, 32'd2);
        check("midrst_aborted", 32'(pulses < 24), 32'd1);
        repeat (2) @(negedge ACLK);
        ARESETN = 1'b1; m_tx = '0; m_done = 1'b0; m_ovr = 1'b0;
        repeat (FRAME) @(negedge ACLK);
        axi_read(4'hC, r); check("midrst_status", r, 32'h0);
        axi_read(4'h4, r); check("midrst_tx", r, {8'd0, m_tx});
        check("midrst_cs_idle", {31'd0, spi_cs_n}, 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/adl_spi_axil_bridge.md
ADL_SPI_AXIL_BRIDGE -- requirements
Module: adl_spi_axil_bridge

Interface
REQ-001 SHALL have parameter C_S_AXI_DATA_WIDTH, default 32, AXI4-Lite data width (only 32 supported).
REQ-002 SHALL have parameter C_S_AXI_ADDR_WIDTH, default 4, byte address width covering four 32-bit registers.
REQ-003 SHALL have parameter CLK_DIV, default 4, ACLK cycles per SCLK half-period (minimum 2).
REQ-004 SHALL have ports `ACLK in 1` (sole clock) and `ARESETN in 1` (synchronous, active-low reset).
REQ-005 SHALL have AXI4-Lite write ports: `S_AXI_AWADDR in 4`, `S_AXI_AWPROT in 3` (ignored), `S_AXI_AWVALID in 1`, `S_AXI_AWREADY out 1`, `S_AXI_WDATA in 32`, `S_AXI_WSTRB in 4`, `S_AXI_WVALID in 1`, `S_AXI_WREADY out 1`, `S_AXI_BRESP out 2`, `S_AXI_BVALID out 1`, `S_AXI_BREADY in 1`.
REQ-006 SHALL have AXI4-Lite read ports: `S_AXI_ARADDR in 4`, `S_AXI_ARPROT in 3` (ignored), `S_AXI_ARVALID in 1`, `S_AXI_ARREADY out 1`, `S_AXI_RDATA out 32`, `S_AXI_RRESP out 2`, `S_AXI_RVALID out 1`, `S_AXI_RREADY in 1`.
REQ-007 SHALL have SPI ports: `spi_cs_n out 1` (ADL5960 chip select, active low), `spi_sclk out 1`, `spi_mosi out 1`, `spi_miso in 1`.

Function
REQ-008 Register map SHALL be: 0x0 CTRL (bit0 START, write-1 pulse, reads 0); 0x4 TXDATA (bits[23:0] R/W, frame {rw, addr[14:0], data[7:0]}); 0x8 RXDATA (bits[7:0] RO); 0xC STATUS (bit0 BUSY RO, bit1 DONE W1C, bit2 OVERRUN W1C).
REQ-009 Write SHALL complete only when AWVALID and WVALID are both high and BVALID is low: AWREADY and WREADY pulse high together for exactly one cycle, and the register updates that same edge.
REQ-010 BVALID SHALL assert the cycle after the AW/W handshake and hold until BREADY; BRESP SHALL always be 2'b00.
REQ-011 WSTRB SHALL gate byte lanes of TXDATA; CTRL START and STATUS W1C bits SHALL act only when WSTRB[0]=1.
REQ-012 ARREADY SHALL pulse for one cycle when ARVALID=1 and RVALID=0; RVALID SHALL assert the next cycle with RDATA latched, and both SHALL hold until RREADY; RRESP SHALL always be 2'b00.
REQ-013 Reads of unused bits SHALL return 0.
REQ-014 SPI FSM states SHALL be IDLE, SETUP, SHIFT, HOLD.
REQ-015 IDLE->SETUP on an accepted START write while not busy: TXDATA is copied into the shift register, spi_cs_n goes low, and spi_mosi shows bit23 on the next edge.
REQ-016 SETUP SHALL last CLK_DIV cycles, then go to SHIFT.
REQ-017 SHIFT SHALL produce 24 SPI mode-0 SCLK periods (low CLK_DIV, then high CLK_DIV), MSB first: MISO is sampled on each rising SCLK edge and MOSI advances on each falling edge.
REQ-018 After the 24th falling edge, the FSM SHALL go to HOLD for CLK_DIV cycles with SCLK low, then return to IDLE with spi_cs_n high.
REQ-019 On HOLD->IDLE, the FSM SHALL clear BUSY, set DONE, and load RXDATA with the last 8 bits received. Total BUSY time SHALL be 50*CLK_DIV cycles.
REQ-020 START while BUSY SHALL be ignored, with OVERRUN set to 1; the in-flight frame SHALL be unaffected.
REQ-021 A TXDATA write while BUSY SHALL update the register but not the in-flight frame.
REQ-022 If DONE set and a DONE W1C occur in the same cycle, set SHALL win.
REQ-023 If a read and a write handshake occur in the same cycle, both SHALL be serviced independently.

Reset
REQ-024 While ARESETN=0 at a rising ACLK edge, the block SHALL set: all READY/VALID outputs 0, RDATA 0, BRESP/RRESP 0, spi_cs_n 1, spi_sclk 0, spi_mosi 0, FSM IDLE, and all registers 0.
REQ-025 Reset asserted mid-frame SHALL abort the frame immediately: spi_cs_n goes to 1 on the reset edge and DONE is not set.

Configuration
REQ-026 With macro ADL_SPI_LOOPBACK_EN defined, the internal MISO sample SHALL be taken from spi_mosi and spi_miso SHALL be ignored; when the macro is undefined, MISO SHALL come from spi_miso. Ports SHALL be identical in both builds.

Verification
REQ-027 Write 0x00A5C33C to 0x4 with WSTRB=0xF, then read 0x4 -> 0x00A5C33C; read 0x0 -> 0x00000000.
REQ-028 Write 0x1 to 0x0 (CLK_DIV=4) -> spi_cs_n low for 200 cycles, 24 SCLK pulses, MOSI bits = 0xA5C33C MSB first; STATUS reads 0x1 during the frame and 0x2 after it.
REQ-029 Drive spi_miso with 0x0000D7 during the frame -> RXDATA reads 0x000000D7; with ADL_SPI_LOOPBACK_EN and TXDATA 0x00A5C33C -> RXDATA reads 0x0000003C.
REQ-030 Write START again at cycle 50 of a frame -> STATUS reads 0x5 during the frame and then 0x6; exactly 24 SCLK pulses occur; write 0x6 to 0xC -> STATUS reads 0x0.
REQ-031 Present AWVALID 3 cycles before WVALID and hold BREADY low for 5 cycles -> AWREADY and WREADY pulse together once, and BVALID holds for 5 cycles; RREADY held low -> RVALID and RDATA stable.
REQ-032 Pull ARESETN low at cycle 100 of a frame -> spi_cs_n=1, spi_sclk=0, STATUS=0x0 after reset.
